// File: rtl/mod_74x194_chain_pkg.sv
// Shared definitions for the cascadable 74x194 universal shift register model:
// mode encodings, slice width and the per-chip next-state function.
package mod_74x194_chain_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    typedef logic [0:SLICE_W-1] slice_t;

    // Index 0 is QA. Shift-right moves data towards QD and shift-left towards QA.
    // Serial inputs are only looked at in the shift modes, so they never leak into hold or load.
    function automatic slice_t slice_next(
        input mode_e  mode,
        input slice_t q,
        input logic   sr,
        input logic   sl,
        input slice_t d
    );
        slice_t n;
        n = q;
        case (mode)
            MODE_HOLD: n = q;
            MODE_SHR:  n = {sr, q[0:SLICE_W-2]};
            MODE_SHL:  n = {q[1:SLICE_W-1], sl};
            MODE_LOAD: n = d;
            default:   n = q;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mod_74x194_slice.sv
// One 74x194 package: 4-bit bidirectional universal shift register with an
// asynchronous active-high clear.
module mod_74x194_slice
    import mod_74x194_chain_pkg::*;
(
    input  logic CLK,
    input  logic CLR,
    input  logic S1,
    input  logic S0,
    input  logic SR,
    input  logic SL,
    input  logic A,
    input  logic B,
    input  logic C,
    input  logic D,
    output logic QA,
    output logic QB,
    output logic QC,
    output logic QD
);

    slice_t q;
    slice_t q_next;
    mode_e  mode;

    always_comb begin
        mode   = mode_e'({S1, S0});
        q_next = slice_next(mode, q, SR, SL, {A, B, C, D});
    end

    // NOTE: non-blocking assignment keeps every slice updating from the pre-edge state, which is what makes the seam shifts land in exactly one edge.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            q <= '0;
        end else begin
            q <= q_next;
        end
    end

    assign {QA, QB, QC, QD} = q;

endmodule

// File: rtl/mod_74x194_chain.sv
// N_CHIPS cascaded 74x194 slices behaving as one W = 4*N_CHIPS bit register,
// with the serial pins chained at every seam exactly as on a board.
module mod_74x194_chain
    import mod_74x194_chain_pkg::*;
#(
    parameter int N_CHIPS = 1
) (
    input  logic                         CLK,
    input  logic                         CLR,
    input  logic                         S1,
    input  logic                         S0,
    input  logic                         SR_SER,
    input  logic                         SL_SER,
    input  logic [0:SLICE_W*N_CHIPS-1]   D,
    output logic [0:SLICE_W*N_CHIPS-1]   Q
);

    localparam int W = SLICE_W * N_CHIPS;

    logic sr_link [N_CHIPS];
    logic sl_link [N_CHIPS];

    for (genvar k = 0; k < N_CHIPS; k++) begin : g_chip
        localparam int BASE = SLICE_W * k;

        // QD of the previous chip feeds SR; the outermost chip takes the external pin.
        if (k == 0) begin : g_sr_ext
            assign sr_link[k] = SR_SER;
        end else begin : g_sr_seam
            assign sr_link[k] = Q[BASE-1];
        end

        if (k == N_CHIPS - 1) begin : g_sl_ext
            assign sl_link[k] = SL_SER;
        end else begin : g_sl_seam
            assign sl_link[k] = Q[BASE+SLICE_W];
        end

        mod_74x194_slice u_slice (
            .CLK (CLK),
            .CLR (CLR),
            .S1  (S1),
            .S0  (S0),
            .SR  (sr_link[k]),
            .SL  (sl_link[k]),
            .A   (D[BASE+0]),
            .B   (D[BASE+1]),
            .C   (D[BASE+2]),
            .D   (D[BASE+3]),
            .QA  (Q[BASE+0]),
            .QB  (Q[BASE+1]),
            .QC  (Q[BASE+2]),
            .QD  (Q[BASE+3])
        );
    end

    if (W != SLICE_W * N_CHIPS) begin : g_bad_width
        $error("register width does not match chip count");
    end

endmodule

// File: tb/tb_mod_74x194_chain.sv
// Directed bench for mod_74x194_chain: a driver pushes hand-computed expected
// register values into a scoreboard queue and a monitor compares them.
module tb_mod_74x194_chain;

    logic       clk;
    logic       clr;
    logic       s1;
    logic       s0;
    logic       sr_ser;
    logic       sl_ser;
    logic [0:3] d1;
    logic [0:3] q1;
    logic [0:7] d2;
    logic [0:7] q2;

    typedef struct {
        string      name;
        int         which;
        logic [7:0] exp;
    } sb_entry_t;

    sb_entry_t sb[$];
    event      sample_ev;
    int        n_tests = 0;
    int        n_fail  = 0;

    mod_74x194_chain #(.N_CHIPS(1)) u_dut1 (
        .CLK    (clk),
        .CLR    (clr),
        .S1     (s1),
        .S0     (s0),
        .SR_SER (sr_ser),
        .SL_SER (sl_ser),
        .D      (d1),
        .Q      (q1)
    );

    mod_74x194_chain #(.N_CHIPS(2)) u_dut2 (
        .CLK    (clk),
        .CLR    (clr),
        .S1     (s1),
        .S0     (s0),
        .SR_SER (sr_ser),
        .SL_SER (sl_ser),
        .D      (d2),
        .Q      (q2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic expect_q(input int which, input logic [7:0] exp, input string name);
        sb_entry_t e;
        e.name  = name;
        e.which = which;
        e.exp   = exp;
        sb.push_back(e);
    endtask

    // Wait for the next rising edge and leave inputs settled 1 time unit after it.
    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_mode(input logic [1:0] m);
        {s1, s0} = m;
    endtask

    // Monitor: compares every queued expectation against the named DUT.
    initial begin
        sb_entry_t e;
        logic [7:0] act;
        forever begin
            @(negedge clk or sample_ev);
            while (sb.size() > 0) begin
                e   = sb.pop_front();
                act = (e.which == 1) ? {4'b0000, q1} : q2;
                check(e.name, act, e.exp);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clr    = 1'b1;
        set_mode(2'b11);
        sr_ser = 1'b0;
        sl_ser = 1'b0;
        d1     = 4'b1111;
        d2     = 8'b1111_1111;

        // 1: reset holds Q at zero while clocks run with load selected.
        #1;
        expect_q(1, 8'h00, "reset_state");
        for (int i = 0; i < 3; i++) begin
            edge_step();
            expect_q(1, 8'h00, "reset_hold");
        end
        expect_q(2, 8'h00, "reset_state_w8");
        clr = 1'b0;
        edge_step();
        expect_q(1, 8'b0000_1111, "release_load");

        // 2: load then hold with different D.
        d1 = 4'b1010;
        edge_step();
        expect_q(1, 8'b0000_1010, "load_1010");
        set_mode(2'b00);
        d1 = 4'b0101;
        for (int i = 0; i < 3; i++) begin
            edge_step();
            expect_q(1, 8'b0000_1010, "hold");
        end

        // 3: shift right a single one out of QD.
        set_mode(2'b11);
        d1 = 4'b1000;
        edge_step();
        expect_q(1, 8'b0000_1000, "load_1000");
        set_mode(2'b01);
        sr_ser = 1'b0;
        edge_step(); expect_q(1, 8'b0000_0100, "shr_1");
        edge_step(); expect_q(1, 8'b0000_0010, "shr_2");
        edge_step(); expect_q(1, 8'b0000_0001, "shr_3");
        edge_step(); expect_q(1, 8'b0000_0000, "shr_4");

        // 4: shift left with ones entering at QD.
        set_mode(2'b11);
        d1 = 4'b0001;
        edge_step();
        expect_q(1, 8'b0000_0001, "load_0001");
        set_mode(2'b10);
        sl_ser = 1'b1;
        edge_step(); expect_q(1, 8'b0000_0011, "shl_1");
        edge_step(); expect_q(1, 8'b0000_0111, "shl_2");

        // 5: two chips, bits crossing the seam in both directions.
        set_mode(2'b11);
        d2 = 8'b0001_0000;
        edge_step();
        expect_q(2, 8'b0001_0000, "w8_load");
        set_mode(2'b01);
        sr_ser = 1'b0;
        edge_step(); expect_q(2, 8'b0000_1000, "w8_shr_seam");
        set_mode(2'b10);
        sl_ser = 1'b0;
        edge_step(); expect_q(2, 8'b0001_0000, "w8_shl_seam");
        sl_ser = 1'b1;
        edge_step(); expect_q(2, 8'b0010_0001, "w8_shl_sl1");

        // 6: D from a 74x32 stage, then clear asserted between edges.
        set_mode(2'b11);
        d1 = 4'b1000 | 4'b0001;
        edge_step();
        expect_q(1, 8'b0000_1001, "or_load");
        @(negedge clk);
        #2;
        clr = 1'b1;
        #1;
        expect_q(1, 8'h00, "mid_clear");
        expect_q(2, 8'h00, "mid_clear_w8");
        ->sample_ev;
        #1;
        set_mode(2'b00);
        clr = 1'b0;
        edge_step();
        expect_q(1, 8'h00, "after_clear_hold");

        repeat (2) @(negedge clk);
        #1;
        check("scoreboard_drain", 8'(sb.size()), 8'h00);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
